// File: rtl/pulse_width_meter_pkg.sv
// Shared types and helpers for pulse_width_meter.
// Holds the FSM state type and the counter saturation value.
package pulse_width_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

  function automatic int unsigned sat_val(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pulse_width_meter_sat_counter.sv
// Saturating up-counter with clear, increment and load-1.
// Clear acts regardless of the sample enable.
module sat_counter
  import pulse_width_meter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         clr,
  input  logic         inc,
  input  logic         load1,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  localparam logic [W-1:0] MAXV = W'(sat_val(W));

  assign at_max = (cnt == MAXV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ce) begin
      if (load1) begin
        cnt <= W'(1);
      end else if (inc && !at_max) begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/pulse_width_meter.sv
// Measures active-high window widths in enabled samples.
// Range check built only with PULSE_WIDTH_METER_RANGE_CHECK_EN.
module pulse_width_meter
  import pulse_width_meter_pkg::*;
#(
  parameter int          WIDTH_W   = 8,
  parameter int unsigned MIN_WIDTH = 1,
  parameter int unsigned MAX_WIDTH = 255
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic               i_ce,
  input  logic               i_clr,
  input  logic               i_active,
  output logic [WIDTH_W-1:0] o_width,
  output logic               o_valid,
  output logic               o_overflow,
  output logic               o_range_err,
  output logic               o_busy
);

  state_t             state;
  logic               sticky;
  logic [WIDTH_W-1:0] cnt;
  logic               at_max;
  logic               load1;
  logic               inc;
  logic               range_bad;

  assign load1  = (state == ST_ARMED) && i_active;
  assign inc    = (state == ST_MEASURE) && i_active;
  assign o_busy = (state == ST_MEASURE);

  sat_counter #(
    .W(WIDTH_W)
  ) u_cnt (
    .clk   (i_clk),
    .rst_n (i_nrst),
    .ce    (i_ce),
    .clr   (i_clr),
    .inc   (inc),
    .load1 (load1),
    .cnt   (cnt),
    .at_max(at_max)
  );

`ifdef PULSE_WIDTH_METER_RANGE_CHECK_EN
  logic [31:0] cnt_ext;
  assign cnt_ext   = 32'(cnt);
  assign range_bad = (cnt_ext < MIN_WIDTH) |
                     (cnt_ext > MAX_WIDTH) |
                     sticky;
`else
  logic unused_cfg;
  assign unused_cfg = ^{MIN_WIDTH, MAX_WIDTH};
  assign range_bad  = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state       <= ST_IDLE;
      sticky      <= 1'b0;
      o_width     <= '0;
      o_valid     <= 1'b0;
      o_overflow  <= 1'b0;
      o_range_err <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_clr) begin
        state  <= ST_IDLE;
        sticky <= 1'b0;
      end else if (i_ce) begin
        unique case (state)
          ST_IDLE: begin
            if (!i_active) state <= ST_ARMED;
          end
          ST_ARMED: begin
            if (i_active) begin
              state  <= ST_MEASURE;
              sticky <= 1'b0;
            end
          end
          ST_MEASURE: begin
            if (i_active) begin
              if (at_max) sticky <= 1'b1;
            end else begin
              o_width     <= cnt;
              o_overflow  <= sticky;
              o_range_err <= range_bad;
              o_valid     <= 1'b1;
              state       <= ST_ARMED;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench for pulse_width_meter.
// Three instances: default, 4-bit counter, range 3..6.
module tb_pulse_width_meter;

  logic clk = 1'b0;
  logic rst_n;
  logic ce;
  logic clr;
  logic act;

  logic [7:0] w8;
  logic       v8, ov8, re8, b8;
  logic [3:0] w4;
  logic       v4, ov4, re4, b4;
  logic [7:0] wr;
  logic       vr, ovr, rer, br;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef PULSE_WIDTH_METER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  always #5 clk = ~clk;

  pulse_width_meter #(
    .WIDTH_W(8), .MIN_WIDTH(1), .MAX_WIDTH(255)
  ) dut (
    .i_clk(clk), .i_nrst(rst_n), .i_ce(ce),
    .i_clr(clr), .i_active(act),
    .o_width(w8), .o_valid(v8), .o_overflow(ov8),
    .o_range_err(re8), .o_busy(b8)
  );

  pulse_width_meter #(
    .WIDTH_W(4), .MIN_WIDTH(1), .MAX_WIDTH(15)
  ) dut4 (
    .i_clk(clk), .i_nrst(rst_n), .i_ce(ce),
    .i_clr(clr), .i_active(act),
    .o_width(w4), .o_valid(v4), .o_overflow(ov4),
    .o_range_err(re4), .o_busy(b4)
  );

  pulse_width_meter #(
    .WIDTH_W(8), .MIN_WIDTH(3), .MAX_WIDTH(6)
  ) dutr (
    .i_clk(clk), .i_nrst(rst_n), .i_ce(ce),
    .i_clr(clr), .i_active(act),
    .o_width(wr), .o_valid(vr), .o_overflow(ovr),
    .o_range_err(rer), .o_busy(br)
  );

  task automatic tick(input logic a, input logic e,
                      input logic c);
    act = a;
    ce  = e;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic highs(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    act = 1'b0; ce = 1'b1; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp += 5;
    if (w8 !== 8'd0) begin
      n_bad++; $display("FAIL rst_width got %0d want 0", w8);
    end
    if (v8 !== 1'b0) begin
      n_bad++; $display("FAIL rst_valid got %b want 0", v8);
    end
    if (ov8 !== 1'b0) begin
      n_bad++; $display("FAIL rst_ovf got %b want 0", ov8);
    end
    if (re8 !== 1'b0) begin
      n_bad++; $display("FAIL rst_rerr got %b want 0", re8);
    end
    if (b8 !== 1'b0) begin
      n_bad++; $display("FAIL rst_busy got %b want 0", b8);
    end
    rst_n = 1'b1;
    tick(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_window_gen;
    int gen_cnt;
    int vseen;
    gen_cnt = 0;
    vseen = 0;
    tick(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (b8 !== 1'b1) begin
      n_bad++; $display("FAIL gen_busy_rise got %b want 1", b8);
    end
    gen_cnt = 1;
    while (gen_cnt < 5) begin
      tick(1'b1, 1'b1, 1'b0);
      if (v8) vseen++;
      gen_cnt++;
    end
    tick(1'b0, 1'b1, 1'b0);
    n_cmp += 5;
    if (v8 !== 1'b1) begin
      n_bad++; $display("FAIL gen_valid got %b want 1", v8);
    end
    if (w8 !== 8'd5) begin
      n_bad++; $display("FAIL gen_width got %0d want 5", w8);
    end
    if (ov8 !== 1'b0) begin
      n_bad++; $display("FAIL gen_ovf got %b want 0", ov8);
    end
    if (b8 !== 1'b0) begin
      n_bad++; $display("FAIL gen_busy_fall got %b want 0", b8);
    end
    if (vseen != 0) begin
      n_bad++; $display("FAIL gen_early_valid got %0d want 0", vseen);
    end
    tick(1'b0, 1'b1, 1'b0);
    n_cmp += 2;
    if (v8 !== 1'b0) begin
      n_bad++; $display("FAIL gen_valid_once got %b want 0", v8);
    end
    if (w8 !== 8'd5) begin
      n_bad++; $display("FAIL gen_hold got %0d want 5", w8);
    end
  endtask

  task automatic test_active_at_reset;
    int vseen;
    vseen = 0;
    rst_n = 1'b0;
    act = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      if (v8 || b8) vseen++;
    end
    tick(1'b0, 1'b1, 1'b0);
    if (v8) vseen++;
    n_cmp++;
    if (vseen != 0) begin
      n_bad++; $display("FAIL ar_first got %0d events want 0", vseen);
    end
    highs(4);
    tick(1'b0, 1'b1, 1'b0);
    n_cmp += 2;
    if (v8 !== 1'b1) begin
      n_bad++; $display("FAIL ar_valid got %b want 1", v8);
    end
    if (w8 !== 8'd4) begin
      n_bad++; $display("FAIL ar_width got %0d want 4", w8);
    end
    highs(3);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (b8 !== 1'b0 || w8 !== 8'd0) begin
      n_bad++;
      $display("FAIL mid_rst_async got busy=%b w=%0d want 0/0",
               b8, w8);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    highs(2);
    tick(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (v8 !== 1'b0 || b8 !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_rst_discard got v=%b b=%b want 0/0",
               v8, b8);
    end
  endtask

  task automatic test_saturation;
    highs(20);
    tick(1'b0, 1'b1, 1'b0);
    n_cmp += 5;
    if (w4 !== 4'd15) begin
      n_bad++; $display("FAIL sat_width got %0d want 15", w4);
    end
    if (ov4 !== 1'b1) begin
      n_bad++; $display("FAIL sat_ovf got %b want 1", ov4);
    end
    if (re4 !== RC) begin
      n_bad++; $display("FAIL sat_rerr got %b want %b", re4, RC);
    end
    if (w8 !== 8'd20 || ov8 !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_w8 got %0d/%b want 20/0", w8, ov8);
    end
    if (v4 !== 1'b1) begin
      n_bad++; $display("FAIL sat_valid got %b want 1", v4);
    end
    highs(3);
    tick(1'b0, 1'b1, 1'b0);
    n_cmp += 2;
    if (w4 !== 4'd3) begin
      n_bad++; $display("FAIL sat_next_w got %0d want 3", w4);
    end
    if (ov4 !== 1'b0 || re4 !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_next_flags got %b/%b want 0/0",
               ov4, re4);
    end
  endtask

  task automatic test_ce;
    for (int i = 0; i < 8; i++)
      tick(1'b1, (i % 2 == 0), 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    n_cmp += 2;
    if (v8 !== 1'b1) begin
      n_bad++; $display("FAIL ce_valid got %b want 1", v8);
    end
    if (w8 !== 8'd4) begin
      n_bad++; $display("FAIL ce_width got %0d want 4", w8);
    end
    tick(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (v8 !== 1'b0) begin
      n_bad++; $display("FAIL ce_strobe got %b want 0", v8);
    end
    tick(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_clear_collision;
    highs(6);
    tick(1'b0, 1'b1, 1'b1);
    n_cmp += 3;
    if (v8 !== 1'b0) begin
      n_bad++; $display("FAIL clr_valid got %b want 0", v8);
    end
    if (w8 !== 8'd4) begin
      n_bad++; $display("FAIL clr_hold got %0d want 4", w8);
    end
    if (b8 !== 1'b0) begin
      n_bad++; $display("FAIL clr_busy got %b want 0", b8);
    end
    tick(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (b8 !== 1'b0) begin
      n_bad++; $display("FAIL clr_idle got busy=%b want 0", b8);
    end
    tick(1'b0, 1'b1, 1'b0);
    highs(2);
    tick(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (v8 !== 1'b1 || w8 !== 8'd2) begin
      n_bad++;
      $display("FAIL clr_recover got v=%b w=%0d want 1/2", v8, w8);
    end
  endtask

  task automatic test_back_to_back;
    int lens [4];
    bit errs [4];
    lens = '{2, 3, 6, 7};
    errs = '{RC, 1'b0, 1'b0, RC};
    for (int k = 0; k < 4; k++) begin
      highs(lens[k]);
      tick(1'b0, 1'b1, 1'b0);
      n_cmp += 3;
      if (vr !== 1'b1) begin
        n_bad++; $display("FAIL b2b_valid[%0d] got %b want 1", k, vr);
      end
      if (wr !== 8'(lens[k])) begin
        n_bad++;
        $display("FAIL b2b_width[%0d] got %0d want %0d",
                 k, wr, lens[k]);
      end
      if (rer !== errs[k]) begin
        n_bad++;
        $display("FAIL range_err[%0d] got %b want %b",
                 k, rer, errs[k]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_window_gen;
    test_active_at_reset;
    test_saturation;
    test_ce;
    test_clear_collision;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_width_meter.md
# pulse_width_meter

Measures the length of active-high windows on a single input, in units of enabled clock samples, and reports each completed width with a one-cycle valid strobe. It is the receive-side counterpart of our one-shot window generators: it sits downstream of any block that drives an `o_active`-style window and checks that window's duration. Typical uses are self-check in the test harness and runtime monitoring of timing windows in the datapath.

## Interface
- `WIDTH_W`, 8: width of the measurement counter and of `o_width`; saturation value is 2^WIDTH_W−1.
- `MIN_WIDTH`, 1: smallest legal width, used only by the range check.
- `MAX_WIDTH`, 255: largest legal width, used only by the range check; must be ≤ 2^WIDTH_W−1.

Ports:
- `i_clk`, in, 1: the single clock.
- `i_nrst`, in, 1: reset, asynchronous and active-low.
- `i_ce`, in, 1: sample enable. State, counter and result registers update only on clock edges where `i_ce`=1.
- `i_clr`, in, 1: synchronous abort. Acts regardless of `i_ce`.
- `i_active`, in, 1: the window being measured.
- `o_width`, out, WIDTH_W: last completed width.
- `o_valid`, out, 1: one-clock strobe marking a new `o_width`.
- `o_overflow`, out, 1: the last result saturated.
- `o_range_err`, out, 1: the last result lies outside [MIN_WIDTH, MAX_WIDTH].
- `o_busy`, out, 1: high while in state MEASURE.

## Operation
- **States.**
  - IDLE: entered on reset or `i_clr`. Waits for an enabled sample with `i_active`=0, then moves to ARMED. This rejects windows already in progress at reset.
  - ARMED: an enabled sample with `i_active`=1 moves to MEASURE and sets cnt=1.
  - MEASURE: an enabled sample with `i_active`=1 does cnt←cnt+1. An enabled sample with `i_active`=0 completes the result and returns to ARMED.
- **Saturation.** cnt never wraps. A high sample while cnt=2^WIDTH_W−1 leaves cnt unchanged and sets an internal sticky overflow bit. The sticky bit clears on entry to MEASURE.
- **Completion.** On completion, register all three together:
  - `o_width`←cnt
  - `o_overflow`←sticky bit
  - `o_range_err`←(cnt<MIN_WIDTH)|(cnt>MAX_WIDTH)|sticky
  - `o_valid`←1
- **Result hold.** `o_width`, `o_overflow` and `o_range_err` hold until the next completion.
- **Clear.** `i_clr`=1 forces state IDLE, cnt=0 and sticky bit=0, and leaves the result registers unchanged. `i_clr` wins over a simultaneous completion: no `o_valid`, no result update.
- **Back-to-back windows.** A single low sample between two windows is sufficient; the second window is measured.

## Timing
- **Reset values.** All outputs are 0; state IDLE; cnt 0.
- **Result latency.** `o_valid` rises on the clock edge that samples the terminating low (enabled edge) and is high for exactly one `i_clk` cycle, even if `i_ce` is low on the following cycle.
- **Measured width.** Equals the number of enabled edges on which `i_active`=1 was sampled in that window.
- **`o_busy`.** Rises on the edge entering MEASURE and falls on the completion edge.
- **Reset mid-window.** Discards the window. The block then requires a low sample before it measures again.

## Configuration
- `PULSE_WIDTH_METER_RANGE_CHECK_EN` defined: `o_range_err` is computed as above, and MIN_WIDTH/MAX_WIDTH are used.
- `PULSE_WIDTH_METER_RANGE_CHECK_EN` undefined: `o_range_err` is tied to 0, no comparators are built, and MIN_WIDTH/MAX_WIDTH are ignored. All other behaviour is identical.

## Structure
- **Shared package.** Holds the state typedef (IDLE, ARMED, MEASURE; 2-bit enum) and the saturation-value function of WIDTH_W.
- **Sub-module `sat_counter`.** WIDTH_W-bit saturating up-counter with clear, increment and load-1 controls plus an `at_max` output. The FSM and result registers stay in the top module.

## Test plan
- **Pairing with the window generator.** Drive `i_active` from a window generator with MAX_VAL=5 and `i_ce`=1. Expect `o_width`=5 and `o_valid` high exactly one cycle, on the edge after the last high sample; `o_overflow`=0.
- **Window active at reset.** Release `i_nrst` while `i_active`=1 for 3 cycles, then drive low 1 cycle and high 4 cycles. Expect no result for the first window; the second gives `o_width`=4.
- **Saturation.** WIDTH_W=4, 20-cycle window. Expect `o_width`=15, `o_overflow`=1, `o_range_err`=1 when the macro is defined. A following 3-cycle window gives `o_width`=3, `o_overflow`=0.
- **Sample enable.** `i_ce` toggling 1,0,1,0 while an 8-clock window is high. Expect `o_width`=4.
- **Clear collision.** Assert `i_clr` on the terminating-low edge of a 6-cycle window. Expect no `o_valid`, `o_width` keeping its prior value, and state IDLE.
- **Range check.** MIN_WIDTH=3, MAX_WIDTH=6 with windows of 2, 3, 6 and 7. Expect `o_range_err`=1,0,0,1 when the macro is defined, and 0,0,0,0 when it is undefined.
